// File: rtl/uart_tx_fifo_module.sv
// uart_tx_fifo_module: buffered RS232 transmitter. Each frame is a start bit, DATA_BITS sent LSB first,
// an optional parity bit and 1 or 2 stop bits. Frames from the FIFO are sent back-to-back.
// Optional feature: define UART_TX_CTS_EN to add the CTS_N clear-to-send input.

// uart_tx_fifo_buf: circular FIFO with occupancy count and a combinational head read.
// Latency: a push is visible at the head one cycle later; a pop takes effect at the next edge.
// Backpressure: push_rdy is low when full and a push is then ignored; pop_rdy is honoured only when pop_vld is high.
module uart_tx_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_vld,
    input  logic [WIDTH-1:0]          push_dat,
    output logic                      push_rdy,
    input  logic                      pop_rdy,
    output logic                      pop_vld,
    output logic [WIDTH-1:0]          pop_dat,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign push_rdy = (count != CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign do_push  = push_vld & push_rdy;
    assign do_pop   = pop_rdy & pop_vld;
    assign pop_dat  = mem[rd_ptr];
    assign level    = count;

    // Storage needs no reset: count decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// uart_tx_fifo_module: queues TX_Data and serialises it on TX_Pin_Out (line idles high).
// Latency: a push at cycle N into an idle block pops at N+1 and drives the start bit at N+2.
// Backpressure: TX_Ready low when the FIFO is full; writes while full are dropped and set sticky TX_Overflow.
module uart_tx_fifo_module #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
`ifdef UART_TX_CTS_EN
    input  logic                          CTS_N,
`endif
    input  logic                          TX_En_Sig,
    input  logic [DATA_BITS-1:0]          TX_Data,
    output logic                          TX_Ready,
    output logic                          TX_Busy,
    output logic                          TX_Done_Sig,
    output logic                          TX_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_Level,
    output logic                          TX_Pin_Out
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q,  state_nxt;
    logic [CNT_W-1:0]       cnt_q,    cnt_nxt;
    logic [2:0]             bit_q,    bit_nxt;
    logic [DATA_BITS-1:0]   shreg_q,  shreg_nxt;
    logic                   par_q,    par_nxt;
    logic                   boundary;
    logic                   done_c;
    logic                   fifo_pop;
    logic                   fifo_vld;
    logic                   fifo_rdy;
    logic [DATA_BITS-1:0]   fifo_dat;
    logic                   start_ok;
    logic                   overflow_q;

    uart_tx_fifo_buf #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push_vld (TX_En_Sig),
        .push_dat (TX_Data),
        .push_rdy (fifo_rdy),
        .pop_rdy  (fifo_pop),
        .pop_vld  (fifo_vld),
        .pop_dat  (fifo_dat),
        .level    (FIFO_Level)
    );

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync;

    // Two-flop synchroniser; resets to "not clear" so nothing is sent before CTS is actually seen.
    always_ff @(posedge CLK) begin
        if (RST) cts_sync <= 2'b11;
        else     cts_sync <= {cts_sync[0], CTS_N};
    end

    // CTS only gates the start of a frame; a frame already on the line always completes.
    assign start_ok = fifo_vld & ~cts_sync[1];
`else
    assign start_ok = fifo_vld;
`endif

    // Sticky overflow: any write attempt while the FIFO is full.
    always_ff @(posedge CLK) begin
        if (RST)                       overflow_q <= 1'b0;
        else if (TX_En_Sig & ~fifo_rdy) overflow_q <= 1'b1;
    end

    // Frame sequencer state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            bit_q   <= bit_nxt;
            shreg_q <= shreg_nxt;
            par_q   <= par_nxt;
        end
    end

    // Next-state: the baud counter free-runs while framing; the head is popped in IDLE or on the last stop cycle.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        bit_nxt   = bit_q;
        shreg_nxt = shreg_q;
        par_nxt   = par_q;
        fifo_pop  = 1'b0;
        done_c    = 1'b0;
        boundary  = (cnt_q == CNT_MAX);

        if (state_q != ST_IDLE) begin
            cnt_nxt = boundary ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (start_ok) begin
                    fifo_pop  = 1'b1;
                    shreg_nxt = fifo_dat;
                    par_nxt   = (PARITY_MODE == 1) ? ~(^fifo_dat) : ^fifo_dat;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (boundary) begin
                    bit_nxt   = '0;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (boundary) begin
                    shreg_nxt = shreg_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_nxt = bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (boundary) begin
                    bit_nxt   = '0;
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (boundary) begin
                    if (bit_q == STOP_LAST) begin
                        done_c  = 1'b1;
                        bit_nxt = '0;
                        if (start_ok) begin
                            // Zero-gap chaining straight into the next start bit.
                            fifo_pop  = 1'b1;
                            shreg_nxt = fifo_dat;
                            par_nxt   = (PARITY_MODE == 1) ? ~(^fifo_dat) : ^fifo_dat;
                            state_nxt = ST_START;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        bit_nxt = bit_q + 3'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Line level is a pure function of registered state, so it is glitch-free.
    always_comb begin
        TX_Pin_Out = 1'b1;
        case (state_q)
            ST_START:  TX_Pin_Out = 1'b0;
            ST_DATA:   TX_Pin_Out = shreg_q[0];
            ST_PARITY: TX_Pin_Out = par_q;
            default:   TX_Pin_Out = 1'b1;
        endcase
    end

    assign TX_Ready    = fifo_rdy;
    assign TX_Busy     = (state_q != ST_IDLE) | fifo_vld;
    assign TX_Done_Sig = done_c;
    assign TX_Overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo_module.sv
// tb_uart_tx_fifo_module: three transmitters (no parity/1 stop, even/2 stop, odd/1 stop) driven in parallel.
// A behavioural receiver per instance decodes frames and checks them against a scoreboard queue.
// Define UART_TX_CTS_EN to also exercise the clear-to-send hold and release.
module tb_uart_tx_fifo_module;
    localparam int CPB  = 4;
    localparam int NDUT = 3;

    logic clk;
    logic rst;
    logic en;
    logic [7:0] dat;
`ifdef UART_TX_CTS_EN
    logic cts_n;
`endif
    logic [NDUT-1:0] rdy, busy, done, ovf, pin;
    logic [2:0] lvl [NDUT];

    int flen [NDUT] = '{10, 12, 11};

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        logic       par_odd;
    } vec_t;
    vec_t vecs [8];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [11:0]     exp_q [NDUT][$];
    logic [NDUT-1:0] rx_on = '0;
    int              rx_k      [NDUT];
    logic [11:0]     rx_bits   [NDUT];
    int              rx_start  [NDUT] = '{-1000, -1000, -1000};
    int              done_cnt  [NDUT] = '{0, 0, 0};
    int              b2b_cnt   [NDUT] = '{0, 0, 0};
    int              base_done [NDUT];
    int              base_b2b  [NDUT];

    uart_tx_fifo_module #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .CLK(clk), .RST(rst),
`ifdef UART_TX_CTS_EN
        .CTS_N(cts_n),
`endif
        .TX_En_Sig(en), .TX_Data(dat), .TX_Ready(rdy[0]), .TX_Busy(busy[0]), .TX_Done_Sig(done[0]),
        .TX_Overflow(ovf[0]), .FIFO_Level(lvl[0]), .TX_Pin_Out(pin[0]));

    uart_tx_fifo_module #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .CLK(clk), .RST(rst),
`ifdef UART_TX_CTS_EN
        .CTS_N(cts_n),
`endif
        .TX_En_Sig(en), .TX_Data(dat), .TX_Ready(rdy[1]), .TX_Busy(busy[1]), .TX_Done_Sig(done[1]),
        .TX_Overflow(ovf[1]), .FIFO_Level(lvl[1]), .TX_Pin_Out(pin[1]));

    uart_tx_fifo_module #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .CLK(clk), .RST(rst),
`ifdef UART_TX_CTS_EN
        .CTS_N(cts_n),
`endif
        .TX_En_Sig(en), .TX_Data(dat), .TX_Ready(rdy[2]), .TX_Busy(busy[2]), .TX_Done_Sig(done[2]),
        .TX_Overflow(ovf[2]), .FIFO_Level(lvl[2]), .TX_Pin_Out(pin[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected line bits, bit i = i-th bit period on the wire.
    function automatic logic [11:0] frame_for(input int d, input logic [7:0] b, input logic pe, input logic po);
        case (d)
            0:       return {2'b00, 1'b1, b, 1'b0};
            1:       return {2'b11, pe, b, 1'b0};
            default: return {1'b0, 1'b1, po, b, 1'b0};
        endcase
    endfunction

    task automatic push_expect(input logic [7:0] b, input logic pe, input logic po);
        for (int d = 0; d < NDUT; d++) exp_q[d].push_back(frame_for(d, b, pe, po));
    endtask

    task automatic snap_counts();
        for (int d = 0; d < NDUT; d++) begin
            base_done[d] = done_cnt[d];
            base_b2b[d]  = b2b_cnt[d];
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy != '0 || rx_on != '0) && n < max_cyc);
        check("idle_wait", {busy, rx_on}, 0);
    endtask

    // Receiver: samples mid-bit, aborts on reset, checks done-pulse position and back-to-back starts.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                rx_on[d] = 1'b0;
            end else begin
                if (done[d]) begin
                    done_cnt[d]++;
                    check($sformatf("done_pos[%0d]", d), cyc - rx_start[d], CPB * flen[d] - 1);
                end
                if (rx_on[d]) begin
                    rx_k[d]++;
                end else if (!pin[d]) begin
                    rx_on[d]   = 1'b1;
                    rx_k[d]    = 0;
                    rx_bits[d] = '0;
                    if (cyc - rx_start[d] == CPB * flen[d]) b2b_cnt[d]++;
                    rx_start[d] = cyc;
                end
                if (rx_on[d] && (rx_k[d] % CPB) == CPB / 2) begin
                    rx_bits[d][rx_k[d] / CPB] = pin[d];
                    if (rx_k[d] / CPB == flen[d] - 1) begin
                        rx_on[d] = 1'b0;
                        if (exp_q[d].size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL unexpected_frame[%0d]: got %h expected no frame", d, rx_bits[d]);
                        end else begin
                            check($sformatf("frame[%0d]", d), rx_bits[d], exp_q[d].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [4:0] pe_c;
        int n;
        rst = 1'b1;
        en  = 1'b0;
        dat = '0;
`ifdef UART_TX_CTS_EN
        cts_n = 1'b0;
`endif
        vecs[0] = '{8'hA5, 1'b0, 1'b1};
        vecs[1] = '{8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1};
        vecs[4] = '{8'h3C, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b0};
        vecs[6] = '{8'h55, 1'b0, 1'b1};
        vecs[7] = '{8'h01, 1'b1, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_pin[%0d]", d),  pin[d],  1);
            check($sformatf("rst_rdy[%0d]", d),  rdy[d],  1);
            check($sformatf("rst_busy[%0d]", d), busy[d], 0);
            check($sformatf("rst_done[%0d]", d), done[d], 0);
            check($sformatf("rst_ovf[%0d]", d),  ovf[d],  0);
            check($sformatf("rst_lvl[%0d]", d),  lvl[d],  0);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Single frames from the vector table, with push-to-start latency.
        for (int i = 0; i < 8; i++) begin
            snap_counts();
            @(posedge clk); #1;
            en  = 1'b1;
            dat = vecs[i].data;
            push_expect(vecs[i].data, vecs[i].par_even, vecs[i].par_odd);
            @(posedge clk); #1 en = 1'b0;
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("v%0d_lvl1[%0d]", i, d), lvl[d], 1);
                check($sformatf("v%0d_busy[%0d]", i, d), busy[d], 1);
            end
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("v%0d_start[%0d]", i, d), pin[d], 0);
                check($sformatf("v%0d_lvl0[%0d]", i, d), lvl[d], 0);
            end
            wait_idle(400);
            for (int d = 0; d < NDUT; d++) check($sformatf("v%0d_ndone[%0d]", i, d), done_cnt[d] - base_done[d], 1);
        end

        // Three consecutive pushes: back-to-back frames.
        snap_counts();
        @(posedge clk); #1 en = 1'b1; dat = 8'h11; push_expect(8'h11, 1'b0, 1'b1);
        @(posedge clk); #1 dat = 8'h2A; push_expect(8'h2A, 1'b1, 1'b0);
        @(negedge clk); check("b2b_lvl_n1", lvl[0], 1);
        @(posedge clk); #1 dat = 8'h3F; push_expect(8'h3F, 1'b0, 1'b1);
        @(negedge clk); check("b2b_lvl_n2", lvl[0], 1);
        @(posedge clk); #1 en = 1'b0;
        @(negedge clk); check("b2b_lvl_n3", lvl[0], 2);
        wait_idle(600);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("b2b_ndone[%0d]", d), done_cnt[d] - base_done[d], 3);
            check($sformatf("b2b_gapless[%0d]", d), b2b_cnt[d] - base_b2b[d], 2);
        end

        // Six pushes into a depth-4 FIFO: one popped immediately, four stored, the sixth dropped.
        snap_counts();
        pe_c = 5'b10110;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            en  = 1'b1;
            dat = 8'hC0 + 8'(i);
            if (i < 5) push_expect(8'hC0 + 8'(i), pe_c[i], ~pe_c[i]);
            @(negedge clk);
            if (i == 5) begin
                check("ovf_full_rdy", rdy[0], 0);
                check("ovf_full_lvl", lvl[0], 4);
            end else begin
                check($sformatf("ovf_rdy_%0d", i), rdy[0], 1);
            end
        end
        @(posedge clk); #1 en = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) check($sformatf("ovf_set[%0d]", d), ovf[d], 1);
        wait_idle(1000);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("ovf_ndone[%0d]", d), done_cnt[d] - base_done[d], 5);
            check($sformatf("ovf_sticky[%0d]", d), ovf[d], 1);
            check($sformatf("ovf_rdy_end[%0d]", d), rdy[d], 1);
        end

        // Reset in the middle of the data bits of 0x3C.
        snap_counts();
        @(posedge clk); #1 en = 1'b1; dat = 8'h3C;
        @(posedge clk); #1 en = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("abort_pin[%0d]", d),  pin[d],  1);
            check($sformatf("abort_lvl[%0d]", d),  lvl[d],  0);
            check($sformatf("abort_busy[%0d]", d), busy[d], 0);
            check($sformatf("abort_ovf[%0d]", d),  ovf[d],  0);
        end
        repeat (60) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("abort_ndone[%0d]", d), done_cnt[d] - base_done[d], 0);
            check($sformatf("abort_idle_pin[%0d]", d), pin[d], 1);
        end

        // Recovery after reset.
        snap_counts();
        @(posedge clk); #1 en = 1'b1; dat = 8'h5A; push_expect(8'h5A, 1'b0, 1'b1);
        @(posedge clk); #1 en = 1'b0;
        wait_idle(400);
        for (int d = 0; d < NDUT; d++) check($sformatf("recov_ndone[%0d]", d), done_cnt[d] - base_done[d], 1);

`ifdef UART_TX_CTS_EN
        // Clear-to-send held off, then released; deasserting mid-frame must not truncate it.
        snap_counts();
        @(posedge clk); #1 cts_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 en = 1'b1; dat = 8'h55; push_expect(8'h55, 1'b0, 1'b1);
        @(posedge clk); #1 en = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (pin != '1) n++;
        end
        check("cts_hold_low_cycles", n, 0);
        check("cts_hold_lvl", lvl[0], 1);
        @(posedge clk); #1 cts_n = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pin != '0 && n < 10);
        check("cts_start_within_3", (n <= 4) ? 1 : 0, 1);
        repeat (8) @(posedge clk);
        #1 cts_n = 1'b1;
        wait_idle(400);
        for (int d = 0; d < NDUT; d++) check($sformatf("cts_ndone[%0d]", d), done_cnt[d] - base_done[d], 1);
        #1 cts_n = 1'b0;
`endif

        for (int d = 0; d < NDUT; d++) check($sformatf("scoreboard_empty[%0d]", d), exp_q[d].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
